// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    localparam int DIV_M_DEF = 8;
    localparam int DIV_CNT_W = $clog2(DIV_M_DEF + 1);

    function automatic int cnt_width(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rca_nbit.sv
// N-bit ripple-carry adder; used as the divider's trial subtractor.
module rca_nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[N];

endmodule

// File: rtl/div_mnbit_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// with start/done handshake and held result registers.
module div_mnbit_seq
    import div_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_width(M);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    rem_q, rem_d;
    logic [M-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  dsr_q, dsr_d;
    logic [M-1:0]  quo_q, quo_d;
    logic [M-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [N:0]    shifted;
    logic [N:0]    diff;
    logic          no_borrow;

    assign shifted = (rem_q << 1) | {{N{1'b0}}, dvd_q[M-1]};

    // co=1 from r + ~{0,divisor} + 1 means r >= divisor
    rca_nbit #(
        .N(N + 1)
    ) u_sub (
        .a  (shifted),
        .b  (~{1'b0, dsr_q}),
        .cin(1'b1),
        .s  (diff),
        .co (no_borrow)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d = dividend;
                    dsr_d = divisor;
                    rem_d = '0;
                    cnt_d = '0;
                    quo_d = '0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend[N-1:0];
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = no_borrow ? diff : shifted;
                quo_d = {quo_q[M-2:0], no_borrow};
                dvd_d = {dvd_q[M-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(M - 1)) begin
                    state_d     = DONE;
                    quotient_d  = {quo_q[M-2:0], no_borrow};
                    remainder_d = no_borrow ? diff[N-1:0] : shifted[N-1:0];
                    dbz_d       = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_mnbit_seq.sv
// Self-checking bench for div_mnbit_seq (M=8, N=4): directed cases
// plus random divisions against an arithmetic reference model.
module tb_div_mnbit_seq;

    localparam int M = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [M-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [M-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    logic [M-1:0] hq;
    logic [N-1:0] hr;
    logic         hz;

    always #5 clk = ~clk;

    div_mnbit_seq #(
        .M(M),
        .N(N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_held(input string tag);
        check({tag, ".q_held"}, 32'(quotient), 32'(hq));
        check({tag, ".r_held"}, 32'(remainder), 32'(hr));
        check({tag, ".z_held"}, 32'(div_by_zero), 32'(hz));
    endtask

    task automatic accept(input logic [M-1:0] a, input logic [N-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called in cycle 1 after an accept; leaves the bench in the
    // first IDLE cycle after done.
    task automatic finish(input logic [M-1:0] a, input logic [N-1:0] b,
                          input bit churn, input string tag);
        int cyc;
        int exp_lat;
        logic [M-1:0] eq;
        logic [N-1:0] er;
        logic ez;
        if (b == 0) begin
            eq = '1;
            er = a[N-1:0];
            ez = 1'b1;
            exp_lat = 1;
        end else begin
            eq = M'(int'(a) / int'(b));
            er = N'(int'(a) % int'(b));
            ez = 1'b0;
            exp_lat = M + 1;
        end
        cyc = 1;
        if (churn) start = 1'b1;
        while (done !== 1'b1 && cyc <= 20) begin
            check({tag, ".busy"}, 32'(busy), 32'd1);
            check_held(tag);
            if (churn) begin
                dividend = 8'($urandom);
                divisor  = 4'($urandom);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (churn) begin
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, ".busy_done"}, 32'(busy), 32'd1);
        check({tag, ".q"}, 32'(quotient), 32'(eq));
        check({tag, ".r"}, 32'(remainder), 32'(er));
        check({tag, ".z"}, 32'(div_by_zero), 32'(ez));
        hq = eq;
        hr = er;
        hz = ez;
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".busy_idle"}, 32'(busy), 32'd0);
        check_held({tag, ".idle"});
    endtask

    task automatic run(input logic [M-1:0] a, input logic [N-1:0] b,
                       input string tag);
        accept(a, b);
        finish(a, b, 1'b0, tag);
    endtask

    initial begin
        logic [M-1:0] ra;
        logic [N-1:0] rb;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        hq = '0;
        hr = '0;
        hz = 1'b0;
        #12;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check_held("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(8'd100, 4'd7, "basic");
        run(8'd255, 4'd15, "ext_255_15");
        run(8'd5, 4'd9, "ext_5_9");
        run(8'd255, 4'd1, "ext_255_1");

        run(8'd200, 4'd0, "dbz");
        run(8'd9, 4'd3, "after_dbz");

        accept(8'd60, 4'd7);
        finish(8'd60, 4'd7, 1'b1, "busy_start");
        accept(8'd77, 4'd5);
        finish(8'd77, 4'd5, 1'b0, "busy_second");

        accept(8'd123, 4'd11);
        finish(8'd123, 4'd11, 1'b0, "b2b_first");
        accept(8'd250, 4'd13);
        finish(8'd250, 4'd13, 1'b0, "b2b_second");

        accept(8'd100, 4'd7);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        hq = '0;
        hr = '0;
        hz = 1'b0;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check_held("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("midrst.no_done", 32'(done), 32'd0);
            check("midrst.idle_busy", 32'(busy), 32'd0);
        end
        run(8'd100, 4'd7, "post_rst");

        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom);
            rb = (i % 6 == 5) ? 4'd0 : 4'($urandom);
            run(ra, rb, $sformatf("rand%0d_%0d_%0d", i, ra, rb));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
